// File: rtl/sdram_frame_reader.sv
// Avalon-MM burst-read master that scans a frame buffer and keeps a downstream pixel FIFO topped up.
// Optional ping-pong base selection is enabled by defining SDR_RD_PINGPONG_EN.
module sdram_frame_reader #(
    parameter int ADDR_W         = 26,
    parameter int BURST_W        = 10,
    parameter int BURST_LEN      = 512,
    parameter int BYTES_PER_WORD = 2,
    parameter int USEDW_W        = 10,
    parameter int FIFO_DEPTH     = 1024,
    parameter int MAX_OUTST      = 2
) (
    input  logic               clk,
    input  logic               rst,
`ifdef SDR_RD_PINGPONG_EN
    input  logic [ADDR_W-1:0]  frame_base_b,
    input  logic               swap_req,
    output logic               buf_sel,
`endif
    input  logic               enable,
    input  logic [ADDR_W-1:0]  frame_base,
    input  logic [ADDR_W-1:0]  frame_words,
    output logic               avm_read,
    output logic [ADDR_W-1:0]  avm_address,
    output logic [BURST_W-1:0] avm_burstcount,
    input  logic               avm_waitrequest,
    input  logic               avm_readdatavalid,
    input  logic [USEDW_W-1:0] fifo_wrusedw,
    output logic               frame_start,
    output logic               busy,
    output logic               overrun_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARB   = 2'd1;
    localparam logic [1:0] ST_REQ   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam int PTR_W  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int PEND_W = USEDW_W + 1;
    localparam int CR_W   = USEDW_W + 2;

    logic [1:0]         state_q, state_d;
    logic [ADDR_W-1:0]  cur_addr_q, cur_addr_d;
    logic [ADDR_W-1:0]  rem_q, rem_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [PEND_W-1:0]  pend_q, pend_d;
    logic [1:0]         outst_q, outst_d;
    logic [BURST_W-1:0] ret_cnt_q, ret_cnt_d;
    logic [BURST_W-1:0] len_mem_q [MAX_OUTST];
    logic [BURST_W-1:0] len_mem_d [MAX_OUTST];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic               avm_read_q, avm_read_d;
    logic [ADDR_W-1:0]  avm_address_q, avm_address_d;
    logic [BURST_W-1:0] avm_burstcount_q, avm_burstcount_d;
    logic               frame_start_q, frame_start_d;
    logic               busy_q, busy_d;
    logic               overrun_q, overrun_d;

    logic               acc;
    logic               rdv_ok;
    logic               pop;
    logic               latch;
    logic               credit_ok;
    logic [BURST_W-1:0] next_len;
    logic [CR_W-1:0]    credit_sum;
    logic [ADDR_W-1:0]  rem_after;
    logic [ADDR_W-1:0]  addr_after;
    logic [ADDR_W-1:0]  lat_base;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        ptr_inc = (p == PTR_W'(MAX_OUTST - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1'b1);
    endfunction

    assign acc        = avm_read_q & ~avm_waitrequest;
    assign rdv_ok     = avm_readdatavalid & (pend_q != {PEND_W{1'b0}});
    assign pop        = rdv_ok & ((ret_cnt_q + BURST_W'(1'b1)) == len_mem_q[rd_ptr_q]);
    assign next_len   = (rem_q < ADDR_W'(BURST_LEN)) ? rem_q[BURST_W-1:0] : BURST_W'(BURST_LEN);
    // Credit sum is widened two bits past usedw so the worst case cannot wrap.
    assign credit_sum = CR_W'(fifo_wrusedw) + CR_W'(pend_q) + CR_W'(next_len);
    assign credit_ok  = (credit_sum <= CR_W'(FIFO_DEPTH)) && (outst_q < 2'(MAX_OUTST));
    assign rem_after  = rem_q - ADDR_W'(avm_burstcount_q);
    assign addr_after = cur_addr_q + ADDR_W'(avm_burstcount_q) * ADDR_W'(BYTES_PER_WORD);

`ifdef SDR_RD_PINGPONG_EN
    logic buf_sel_q, buf_sel_d, swap_pend_q, swap_pend_d, sel_next;

    assign sel_next = buf_sel_q ^ swap_pend_q;
    assign lat_base = sel_next ? frame_base_b : frame_base;
    assign buf_sel  = buf_sel_q;

    // Buffer select toggles only at a frame latch; a swap arriving with the latch waits one frame.
    always_comb begin
        if (latch) begin
            buf_sel_d   = sel_next;
            swap_pend_d = swap_req;
        end else begin
            buf_sel_d   = buf_sel_q;
            swap_pend_d = swap_pend_q | swap_req;
        end
    end

    // Ping-pong select registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_sel_q   <= 1'b0;
            swap_pend_q <= 1'b0;
        end else begin
            buf_sel_q   <= buf_sel_d;
            swap_pend_q <= swap_pend_d;
        end
    end
`else
    assign lat_base = frame_base;
`endif

    // Request FSM: frame latch, credit arbitration and request hold until accepted.
    always_comb begin
        state_d          = state_q;
        cur_addr_d       = cur_addr_q;
        rem_d            = rem_q;
        base_d           = base_q;
        avm_read_d       = avm_read_q;
        avm_address_d    = avm_address_q;
        avm_burstcount_d = avm_burstcount_q;
        latch            = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    latch      = 1'b1;
                    cur_addr_d = lat_base;
                    base_d     = lat_base;
                    rem_d      = frame_words;
                    state_d    = ST_ARB;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARB: begin
                if (!enable) begin
                    state_d = ST_DRAIN;
                end else if (credit_ok) begin
                    avm_read_d       = 1'b1;
                    avm_address_d    = cur_addr_q;
                    avm_burstcount_d = next_len;
                    state_d          = ST_REQ;
                end else begin
                    state_d = ST_ARB;
                end
            end
            ST_REQ: begin
                if (acc) begin
                    avm_read_d = 1'b0;
                    if ((rem_after == {ADDR_W{1'b0}}) && enable) begin
                        latch      = 1'b1;
                        cur_addr_d = lat_base;
                        base_d     = lat_base;
                        rem_d      = frame_words;
                        state_d    = ST_ARB;
                    end else if (rem_after == {ADDR_W{1'b0}}) begin
                        cur_addr_d = addr_after;
                        rem_d      = rem_after;
                        state_d    = ST_DRAIN;
                    end else begin
                        cur_addr_d = addr_after;
                        rem_d      = rem_after;
                        state_d    = ST_ARB;
                    end
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (pend_q == {PEND_W{1'b0}}) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                avm_read_d = 1'b0;
            end
        endcase
    end

    // Return path: pending words, per-burst length FIFO and outstanding-burst count.
    always_comb begin
        for (int i = 0; i < MAX_OUTST; i++) begin
            len_mem_d[i] = (acc && (wr_ptr_q == PTR_W'(i))) ? avm_burstcount_q : len_mem_q[i];
        end
        if (acc && rdv_ok) begin
            pend_d = pend_q + PEND_W'(avm_burstcount_q) - PEND_W'(1'b1);
        end else if (acc) begin
            pend_d = pend_q + PEND_W'(avm_burstcount_q);
        end else if (rdv_ok) begin
            pend_d = pend_q - PEND_W'(1'b1);
        end else begin
            pend_d = pend_q;
        end
        if (acc && !pop) begin
            outst_d = outst_q + 2'd1;
        end else if (pop && !acc) begin
            outst_d = outst_q - 2'd1;
        end else begin
            outst_d = outst_q;
        end
        if (pop) begin
            ret_cnt_d = {BURST_W{1'b0}};
        end else if (rdv_ok) begin
            ret_cnt_d = ret_cnt_q + BURST_W'(1'b1);
        end else begin
            ret_cnt_d = ret_cnt_q;
        end
        wr_ptr_d      = acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d      = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        frame_start_d = acc & (avm_address_q == base_q);
        overrun_d     = overrun_q | (avm_readdatavalid & (pend_q == {PEND_W{1'b0}}));
        busy_d        = (state_d != ST_IDLE) | (pend_d != {PEND_W{1'b0}});
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            cur_addr_q       <= {ADDR_W{1'b0}};
            rem_q            <= {ADDR_W{1'b0}};
            base_q           <= {ADDR_W{1'b0}};
            pend_q           <= {PEND_W{1'b0}};
            outst_q          <= 2'd0;
            ret_cnt_q        <= {BURST_W{1'b0}};
            wr_ptr_q         <= {PTR_W{1'b0}};
            rd_ptr_q         <= {PTR_W{1'b0}};
            avm_read_q       <= 1'b0;
            avm_address_q    <= {ADDR_W{1'b0}};
            avm_burstcount_q <= {BURST_W{1'b0}};
            frame_start_q    <= 1'b0;
            busy_q           <= 1'b0;
            overrun_q        <= 1'b0;
            for (int i = 0; i < MAX_OUTST; i++) begin
                len_mem_q[i] <= {BURST_W{1'b0}};
            end
        end else begin
            state_q          <= state_d;
            cur_addr_q       <= cur_addr_d;
            rem_q            <= rem_d;
            base_q           <= base_d;
            pend_q           <= pend_d;
            outst_q          <= outst_d;
            ret_cnt_q        <= ret_cnt_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            avm_read_q       <= avm_read_d;
            avm_address_q    <= avm_address_d;
            avm_burstcount_q <= avm_burstcount_d;
            frame_start_q    <= frame_start_d;
            busy_q           <= busy_d;
            overrun_q        <= overrun_d;
            for (int i = 0; i < MAX_OUTST; i++) begin
                len_mem_q[i] <= len_mem_d[i];
            end
        end
    end

    assign avm_read       = avm_read_q;
    assign avm_address    = avm_address_q;
    assign avm_burstcount = avm_burstcount_q;
    assign frame_start    = frame_start_q;
    assign busy           = busy_q;
    assign overrun_err    = overrun_q;

endmodule

// File: tb/tb_sdram_frame_reader.sv
// Randomised self-checking bench for sdram_frame_reader against a burst-list / word-count model.
module tb_sdram_frame_reader;

    localparam int BL    = 512;
    localparam int DEPTH = 1024;
    localparam int MOUT  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [25:0] frame_base;
    logic [25:0] frame_words;
    logic        avm_read;
    logic [25:0] avm_address;
    logic [9:0]  avm_burstcount;
    logic        avm_waitrequest;
    logic        avm_readdatavalid;
    logic [9:0]  fifo_wrusedw;
    logic        frame_start;
    logic        busy;
    logic        overrun_err;
`ifdef SDR_RD_PINGPONG_EN
    logic [25:0] frame_base_b;
    logic        swap_req;
    logic        buf_sel;
`endif

    int errors = 0;
    int checks = 0;

    // Model: words and bursts accepted but not yet returned.
    int   pend_m, ret_m, acc_cnt;
    int   len_q[$];
    bit   overrun_m, last_acc, rose;
    logic [25:0] last_addr;
    int   last_len, pre_usedw, pre_pend, pre_outst;

    sdram_frame_reader #(
        .ADDR_W(26), .BURST_W(10), .BURST_LEN(BL), .BYTES_PER_WORD(2),
        .USEDW_W(10), .FIFO_DEPTH(DEPTH), .MAX_OUTST(MOUT)
    ) dut (
        .clk(clk), .rst(rst),
`ifdef SDR_RD_PINGPONG_EN
        .frame_base_b(frame_base_b), .swap_req(swap_req), .buf_sel(buf_sel),
`endif
        .enable(enable), .frame_base(frame_base), .frame_words(frame_words),
        .avm_read(avm_read), .avm_address(avm_address), .avm_burstcount(avm_burstcount),
        .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid),
        .fifo_wrusedw(fifo_wrusedw), .frame_start(frame_start), .busy(busy),
        .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;

    function automatic logic [25:0] exp_addr(input logic [25:0] base, input int words, input int k);
        logic [31:0] t;
        int nb;
        nb = (words + BL - 1) / BL;
        t  = 32'(base) + 32'(k % nb) * 32'd1024;
        return t[25:0];
    endfunction

    function automatic int exp_len(input int words, input int k);
        int nb, j;
        nb = (words + BL - 1) / BL;
        j  = k % nb;
        return (j == nb - 1) ? (words - j * BL) : BL;
    endfunction

    task automatic clear_model();
        pend_m = 0; ret_m = 0; acc_cnt = 0; overrun_m = 1'b0;
        last_acc = 1'b0; rose = 1'b0;
        len_q.delete();
    endtask

    // One clock: sample pre-edge bus state, advance, then update the model.
    task automatic step();
        bit acc_n, rdv_n, prev_read;
        acc_n     = avm_read && !avm_waitrequest;
        rdv_n     = avm_readdatavalid;
        prev_read = avm_read;
        pre_usedw = int'(fifo_wrusedw);
        pre_pend  = pend_m;
        pre_outst = len_q.size();
        last_addr = avm_address;
        last_len  = int'(avm_burstcount);
        @(posedge clk); #1;
        last_acc = acc_n;
        rose     = !prev_read && avm_read;
        if (rdv_n) begin
            if (pre_pend == 0) overrun_m = 1'b1;
            else begin
                pend_m--; ret_m++;
                if (ret_m == len_q[0]) begin void'(len_q.pop_front()); ret_m = 0; end
            end
        end
        if (acc_n) begin pend_m += last_len; len_q.push_back(last_len); acc_cnt++; end
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; frame_base = 26'd0; frame_words = 26'd1;
        avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; fifo_wrusedw = 10'd0;
`ifdef SDR_RD_PINGPONG_EN
        frame_base_b = 26'd0; swap_req = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        clear_model();
    endtask

    // Drive a frame scan until n_acc bursts are accepted, checking every cycle.
    task automatic run_scan(input logic [25:0] base, input int words, input int n_acc,
                            input int wr_pct, input int uw_max);
        int cyc = 0;
        int nb  = (words + BL - 1) / BL;
        bit fs_exp;
        frame_base = base; frame_words = 26'(words); enable = 1'b1;
        while (acc_cnt < n_acc && cyc < 20000) begin
            avm_waitrequest   = ($urandom_range(0, 99) < wr_pct);
            fifo_wrusedw      = 10'($urandom_range(0, uw_max));
            avm_readdatavalid = (pend_m > 0) && ($urandom_range(0, 1) == 1);
            step(); cyc++;
            if (last_acc) begin
                checks++;
                if (last_addr !== exp_addr(base, words, acc_cnt - 1)) begin
                    errors++; $display("FAIL burst_addr #%0d: got %h want %h", acc_cnt - 1, last_addr, exp_addr(base, words, acc_cnt - 1));
                end
                checks++;
                if (last_len != exp_len(words, acc_cnt - 1)) begin
                    errors++; $display("FAIL burst_len #%0d: got %0d want %0d", acc_cnt - 1, last_len, exp_len(words, acc_cnt - 1));
                end
            end
            fs_exp = last_acc && (((acc_cnt - 1) % nb) == 0);
            checks++;
            if (frame_start !== fs_exp) begin
                errors++; $display("FAIL frame_start: got %b want %b (acc %0d)", frame_start, fs_exp, acc_cnt);
            end
            if (rose) begin
                checks++;
                if (pre_usedw + pre_pend + int'(avm_burstcount) > DEPTH || pre_outst >= MOUT) begin
                    errors++; $display("FAIL credit: usedw %0d pend %0d len %0d outst %0d", pre_usedw, pre_pend, avm_burstcount, pre_outst);
                end
            end
            checks++;
            if (busy !== 1'b1 || overrun_err !== 1'b0) begin
                errors++; $display("FAIL scan_flags: busy %b overrun %b want 1 0", busy, overrun_err);
            end
        end
        checks++;
        if (acc_cnt < n_acc) begin errors++; $display("FAIL scan_timeout: got %0d bursts want %0d", acc_cnt, n_acc); end
        enable = 1'b0; avm_readdatavalid = 1'b0; avm_waitrequest = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
        fifo_wrusedw = 10'd0; frame_base = 26'd0; frame_words = 26'd1;
`ifdef SDR_RD_PINGPONG_EN
        frame_base_b = 26'd0; swap_req = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({avm_read, avm_address, avm_burstcount, frame_start, overrun_err, busy} !== 40'd0) begin
            errors++; $display("FAIL reset_outputs: read %b addr %h bc %0d fs %b ovr %b busy %b want all 0",
                               avm_read, avm_address, avm_burstcount, frame_start, overrun_err, busy);
        end
`ifdef SDR_RD_PINGPONG_EN
        checks++;
        if (buf_sel !== 1'b0) begin errors++; $display("FAIL reset_buf_sel: got %b want 0", buf_sel); end
`endif
        rst = 1'b0; clear_model();
    endtask

    task automatic test_frame_sequence();
        do_reset();
        frame_base = 26'h1E00000; frame_words = 26'd1300; enable = 1'b1;
        step();
        checks++;
        if (avm_read !== 1'b0) begin errors++; $display("FAIL latency_1: read %b want 0", avm_read); end
        step();
        checks++;
        if (avm_read !== 1'b1 || avm_address !== 26'h1E00000 || avm_burstcount !== 10'd512) begin
            errors++; $display("FAIL latency_2: read %b addr %h bc %0d want 1 1e00000 512", avm_read, avm_address, avm_burstcount);
        end
        run_scan(26'h1E00000, 1300, 4, 0, 0);
    endtask

    task automatic test_waitrequest_hold();
        logic [25:0] a0; logic [9:0] b0; int cyc = 0; bit held = 1'b1;
        do_reset();
        a0 = 26'($urandom) & 26'h3FFFFFE;
        frame_base = a0; frame_words = 26'd1300; avm_waitrequest = 1'b1; enable = 1'b1;
        while (avm_read !== 1'b1 && cyc < 10) begin step(); cyc++; end
        checks++;
        if (avm_address !== a0 || avm_burstcount !== 10'd512) begin
            errors++; $display("FAIL wait_first: addr %h bc %0d want %h 512", avm_address, avm_burstcount, a0);
        end
        b0 = avm_burstcount;
        for (int i = 0; i < 7; i++) begin
            step();
            if (avm_read !== 1'b1 || avm_address !== a0 || avm_burstcount !== b0 || acc_cnt != 0) held = 1'b0;
        end
        checks++;
        if (!held) begin errors++; $display("FAIL wait_hold: read %b addr %h bc %0d acc %0d", avm_read, avm_address, avm_burstcount, acc_cnt); end
        avm_waitrequest = 1'b0;
        step();
        avm_waitrequest = 1'b1;
        repeat (3) step();
        checks++;
        if (acc_cnt != 1) begin errors++; $display("FAIL wait_single_acc: got %0d want 1", acc_cnt); end
    endtask

    task automatic test_credit();
        logic [25:0] a0; bit quiet = 1'b1;
        do_reset();
        a0 = 26'($urandom) & 26'h3FFFFFE;
        frame_base = a0; frame_words = 26'd2000; fifo_wrusedw = 10'd600; enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i >= 5) fifo_wrusedw = 10'($urandom_range(513, 1023));
            step();
            if (avm_read !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin errors++; $display("FAIL credit_block: read rose with usedw above 512"); end
        fifo_wrusedw = 10'd512;
        step();
        checks++;
        if (avm_read !== 1'b1 || avm_address !== a0) begin
            errors++; $display("FAIL credit_release: read %b addr %h want 1 %h", avm_read, avm_address, a0);
        end
    endtask

    task automatic test_outstanding();
        logic [25:0] a0; logic [25:0] got; int cyc;
        // Long frame: two 512-word bursts then stall until the first fully returns.
        do_reset();
        a0 = 26'($urandom) & 26'h3FFFFFE;
        frame_base = a0; frame_words = 26'd5000; enable = 1'b1;
        repeat (40) step();
        checks++;
        if (acc_cnt != 2) begin errors++; $display("FAIL outst_long_two: got %0d want 2", acc_cnt); end
        avm_readdatavalid = 1'b1;
        repeat (511) step();
        checks++;
        if (acc_cnt != 2) begin errors++; $display("FAIL outst_long_early: got %0d want 2", acc_cnt); end
        step();
        avm_readdatavalid = 1'b0;
        cyc = 0; got = 26'd0;
        while (acc_cnt < 3 && cyc < 6) begin step(); cyc++; if (last_acc) got = last_addr; end
        checks++;
        if (acc_cnt != 3 || got !== exp_addr(a0, 5000, 2)) begin
            errors++; $display("FAIL outst_long_third: acc %0d addr %h want 3 %h", acc_cnt, got, exp_addr(a0, 5000, 2));
        end
        // Short frames: credit would allow more, the outstanding limit must hold at 2.
        do_reset();
        frame_base = a0; frame_words = 26'd100; enable = 1'b1;
        repeat (40) step();
        checks++;
        if (acc_cnt != 2) begin errors++; $display("FAIL outst_short_two: got %0d want 2", acc_cnt); end
        avm_readdatavalid = 1'b1;
        repeat (99) step();
        checks++;
        if (acc_cnt != 2) begin errors++; $display("FAIL outst_short_early: got %0d want 2", acc_cnt); end
        step();
        avm_readdatavalid = 1'b0;
        cyc = 0;
        while (acc_cnt < 3 && cyc < 6) begin step(); cyc++; end
        checks++;
        if (acc_cnt != 3 || frame_start !== 1'b1) begin
            errors++; $display("FAIL outst_short_third: acc %0d fs %b want 3 1", acc_cnt, frame_start);
        end
    endtask

    task automatic test_enable_drop();
        logic [25:0] a0; int cyc = 0; bit ok = 1'b1; bit seen = 1'b0;
        do_reset();
        a0 = 26'($urandom) & 26'h3FFFFFE;
        frame_base = a0; frame_words = 26'd5000; enable = 1'b1;
        while (acc_cnt < 2 && cyc < 50) begin step(); cyc++; end
        enable = 1'b0;
        for (int i = 0; i < 30; i++) begin step(); if (busy !== 1'b1 || avm_read !== 1'b0) ok = 1'b0; end
        checks++;
        if (!ok || acc_cnt != 2) begin errors++; $display("FAIL drop_hold: acc %0d busy %b want 2 1", acc_cnt, busy); end
        ok = 1'b1;
        avm_readdatavalid = 1'b1;
        for (int i = 0; i < 1024; i++) begin step(); if (busy !== 1'b1) ok = 1'b0; end
        avm_readdatavalid = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL drop_busy: busy fell before drain completed"); end
        step();
        checks++;
        if (busy !== 1'b0 || overrun_err !== overrun_m) begin
            errors++; $display("FAIL drop_idle: busy %b ovr %b want 0 %b", busy, overrun_err, overrun_m);
        end
        enable = 1'b1; cyc = 0;
        while (!seen && cyc < 10) begin step(); cyc++; if (last_acc) seen = 1'b1; end
        checks++;
        if (!seen || last_addr !== a0 || frame_start !== 1'b1) begin
            errors++; $display("FAIL drop_restart: addr %h fs %b want %h 1", last_addr, frame_start, a0);
        end
    endtask

    task automatic test_overrun();
        int cyc = 0;
        do_reset();
        avm_readdatavalid = 1'b1; step(); avm_readdatavalid = 1'b0;
        checks++;
        if (overrun_err !== 1'b1 || overrun_m !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b want 1", overrun_err); end
        repeat (10) step();
        checks++;
        if (overrun_err !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b want 1", overrun_err); end
        do_reset();
        checks++;
        if (overrun_err !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b want 0", overrun_err); end
        frame_base = 26'($urandom) & 26'h3FFFFFE; frame_words = 26'd3000; enable = 1'b1;
        while (acc_cnt < 1 && cyc < 10) begin step(); cyc++; end
        rst = 1'b1; #2;
        checks++;
        if (busy !== 1'b0 || avm_read !== 1'b0) begin errors++; $display("FAIL rst_async: busy %b read %b want 0 0", busy, avm_read); end
        @(posedge clk); #1;
        rst = 1'b0; enable = 1'b0; clear_model();
        avm_readdatavalid = 1'b1; step(); avm_readdatavalid = 1'b0;
        checks++;
        if (overrun_err !== 1'b1) begin errors++; $display("FAIL rst_late_words: overrun %b want 1", overrun_err); end
    endtask

    task automatic test_random();
        logic [25:0] base;
        int words;
        for (int r = 0; r < 3; r++) begin
            do_reset();
            base  = (r == 0) ? 26'h3FFFC00 : (26'($urandom) & 26'h3FFFFFE);
            words = (r == 0) ? 1500 : $urandom_range(1, 1500);
            run_scan(base, words, (words + BL - 1) / BL + 2, 30, 300);
        end
    endtask

`ifdef SDR_RD_PINGPONG_EN
    task automatic test_pingpong();
        logic [25:0] a0, b0;
        logic [25:0] addrs [4];
        int cyc = 0; bit swapped = 1'b0; logic sel_at_latch = 1'b0;
        do_reset();
        a0 = 26'h0100000; b0 = 26'h0800000;
        frame_base = a0; frame_base_b = b0; frame_words = 26'd600; enable = 1'b1;
        while (acc_cnt < 4 && cyc < 5000) begin
            avm_readdatavalid = (pend_m > 0) && ($urandom_range(0, 1) == 1);
            swap_req = (acc_cnt == 1) && !swapped;
            if (swap_req) swapped = 1'b1;
            step(); cyc++;
            if (last_acc) begin
                addrs[acc_cnt - 1] = last_addr;
                if (acc_cnt == 2) sel_at_latch = buf_sel;
            end
        end
        swap_req = 1'b0; avm_readdatavalid = 1'b0;
        checks++;
        if (acc_cnt != 4 || addrs[0] !== a0 || addrs[1] !== a0 + 26'd1024 || addrs[2] !== b0 || addrs[3] !== b0 + 26'd1024) begin
            errors++; $display("FAIL pingpong_addr: %h %h %h %h want %h %h %h %h", addrs[0], addrs[1], addrs[2], addrs[3],
                               a0, a0 + 26'd1024, b0, b0 + 26'd1024);
        end
        checks++;
        if (sel_at_latch !== 1'b1 || buf_sel !== 1'b1) begin
            errors++; $display("FAIL pingpong_sel: got %b/%b want 1", sel_at_latch, buf_sel);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_frame_sequence();
        test_waitrequest_hold();
        test_credit();
        test_outstanding();
        test_enable_drop();
        test_overrun();
        test_random();
`ifdef SDR_RD_PINGPONG_EN
        test_pingpong();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sdram_frame_reader.md
Name: sdram_frame_reader

Overview:
Parametrised Avalon-MM burst-read master that continuously scans a frame buffer in SDRAM and keeps a downstream pixel FIFO topped up for the LCD path. It is the successor to the fixed 512-word GUI bridge reader. It adds runtime frame base and size, a short final burst, credit-based flow control with multiple outstanding bursts, and strict Avalon hold-under-waitrequest. It sits between the Qsys pipeline bridge (master side) and the source FIFO write-usedw port.

Parameters:
ADDR_W, 26, byte address width on the Avalon bus
BURST_W, 10, width of avm_burstcount
BURST_LEN, 512, maximum words per burst; must be a power of 2 and below 2^BURST_W
BYTES_PER_WORD, 2, address increment per word
USEDW_W, 10, width of fifo_wrusedw
FIFO_DEPTH, 1024, downstream FIFO capacity in words
MAX_OUTST, 2, maximum accepted bursts not yet fully returned (1..3)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
enable  in  1  level; 1 = scan frames
frame_base  in  ADDR_W  byte start address of the frame; sampled at each frame start
frame_words  in  ADDR_W  frame length in words (at least 1); sampled at each frame start
avm_read  out  1  Avalon read request
avm_address  out  ADDR_W  burst byte address
avm_burstcount  out  BURST_W  words in this burst
avm_waitrequest  in  1  slave stall
avm_readdatavalid  in  1  one returned word
fifo_wrusedw  in  USEDW_W  current downstream FIFO fill level
frame_start  out  1  one-cycle pulse when the first burst of a frame is accepted
busy  out  1  high while any burst is outstanding or a request is pending
overrun_err  out  1  sticky flag: readdatavalid seen with pend_words==0; cleared only by rst

Behaviour:
- Reset values: avm_read=0, avm_address=0, avm_burstcount=0, frame_start=0, overrun_err=0. Internally pend_words=0, outst=0, and the state is IDLE.
- Accept event (acc): avm_read & !avm_waitrequest.
- While avm_read=1, avm_address and avm_burstcount are held stable until acc. Deasserting enable does not drop a pending request.
- States:
  - IDLE: if enable, latch cur_addr=frame_base and rem=frame_words, then go to ARB.
  - ARB: next_len = min(BURST_LEN, rem).
    - If !enable, go to DRAIN.
    - Otherwise, when outst<MAX_OUTST and fifo_wrusedw + pend_words + next_len <= FIFO_DEPTH: drive avm_read=1, avm_address=cur_addr, avm_burstcount=next_len, then go to REQ.
  - REQ: on acc, the following updates are registered and take effect the next cycle:
    - avm_read=0;
    - cur_addr += next_len*BYTES_PER_WORD;
    - rem -= next_len;
    - pend_words += next_len;
    - outst += 1.
    Then:
    - if rem becomes 0 and enable=1, re-latch frame_base/frame_words and go to ARB (seamless wrap);
    - if rem becomes 0 and enable=0, go to DRAIN;
    - otherwise go to ARB.
  - DRAIN: wait for pend_words==0, then go to IDLE. The next enable restarts the scan at frame_base.
- frame_start is asserted the cycle after acc of any burst whose address equals the latched frame base at the start of that frame.
- Return path:
  - each avm_readdatavalid decrements pend_words;
  - outst decrements when the returned-word count of the oldest burst reaches its length;
  - per-burst lengths are kept in a MAX_OUTST-deep length FIFO.
  - If acc and readdatavalid happen in the same cycle, both counters update with the net value.
- Arithmetic:
  - pend_words is USEDW_W+1 bits;
  - the credit compare is done in USEDW_W+2 bits with no wrap;
  - cur_addr wraps modulo 2^ADDR_W with no error.
- Latency: ARB to avm_read high is 1 cycle; the first request after enable rises is issued 2 cycles later if credit is available.
- busy = (state!=IDLE) | (pend_words!=0).
- rst asserted mid-burst: all state is discarded immediately, and any words still returning afterwards set overrun_err.

Optional Feature:
Macro SDR_RD_PINGPONG_EN.
- Defined:
  - adds input frame_base_b [ADDR_W], input swap_req (pulse), and output buf_sel (1 bit, reset 0);
  - a swap_req pulse sets a pending flag; at the next frame-start latch buf_sel toggles and the flag clears;
  - the latched base is frame_base when buf_sel=0 and frame_base_b when buf_sel=1;
  - a swap_req arriving in the same cycle as the latch applies to the following frame.
- Not defined: these ports are absent and the block always uses frame_base.

Test Plan:
1. frame_base=0x1E00000, frame_words=1300, BURST_LEN=512, waitrequest=0, usedw=0 -> bursts 512@0x1E00000, 512@0x1E00400, 276@0x1E00800, then 512@0x1E00000 with frame_start pulsing.
2. avm_waitrequest held high for 7 cycles during REQ -> avm_read/address/burstcount stay constant all 7 cycles; a single acc follows.
3. usedw=600 with pend_words=0 -> no request until usedw<=512 (FIFO_DEPTH 1024).
4. MAX_OUTST=2, return words withheld -> exactly 2 bursts accepted; the third is issued only after 512 valids for the first.
5. enable dropped mid-frame while 2 bursts are outstanding -> no new acc; busy stays 1 until 1024 valids, then IDLE; re-enable restarts at frame_base.
6. readdatavalid pulsed with nothing outstanding -> overrun_err=1 and stays 1 until rst; with SDR_RD_PINGPONG_EN, swap_req mid-frame -> next frame uses frame_base_b and buf_sel=1.
